uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one byte-level UART transmitter between NUM_REQ requesters, e.g. the CPU MMIO port and a debug/trace source.
- Round-robin arbiter feeds an internal FIFO of DEPTH bytes.
- A sequencer drains the FIFO into the transmitter with a start/busy handshake.
- Sits between the bus-side UART register logic and the bit-level sender, all in the sysclk domain.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
DEPTH, 8, FIFO entries; power of two, at least 2.
TIMEOUT, 4096, sysclk cycles allowed in each WAIT state (used only with the optional feature).

Ports:
sysclk  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  per-requester byte-valid.
req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
req_ready  out  NUM_REQ  one-hot accept; combinational.
tx_data  out  8  byte presented to the sender; registered.
tx_start  out  1  one-cycle start pulse to the sender; registered.
tx_busy  in  1  sender busy, high while a frame is on the line.
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
idle_irq  out  1  one-cycle pulse when the last queued byte finishes.
tx_err  out  1  one-cycle pulse on handshake timeout (optional feature).

Behaviour:
- Reset (async, reset=0):
  - FIFO emptied, fifo_count=0, state=IDLE.
  - tx_start=0, tx_data=0, idle_irq=0, tx_err=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame drops all queued bytes; a frame already in the sender is not aborted by this block.
- Arbitration:
  - The search starts at pointer+1 and wraps modulo NUM_REQ; the first requester with req_valid=1 is granted.
  - req_ready[g]=1 only if fifo_count<DEPTH.
  - Transfer = req_valid[g]&req_ready[g]. On a transfer, the byte is written at the tail and pointer<=g.
  - At most one push per cycle. Requesters hold req_valid/req_data stable until their ready is seen.
  - Full: all req_ready=0, even if a pop occurs in the same cycle. No data is lost or overwritten.
- FIFO:
  - Circular buffer; head/tail wrap at DEPTH.
  - Push and pop in the same cycle leaves fifo_count unchanged.
  - fifo_count updates on the edge after the push or pop.
- Sequencer FSM:
  - IDLE: if fifo_count!=0 and tx_busy=0 -> START; at that edge, tx_data<=head byte and the byte is popped.
  - START: tx_start=1 for exactly this one cycle -> WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1 -> WAIT_DONE.
  - WAIT_DONE: stay until tx_busy=0 -> IDLE. If fifo_count==0 at that edge, idle_irq pulses high for the next cycle.
  - tx_data holds its value from START until the next START.
- Latency: a byte pushed at edge k into an empty FIFO with an idle sender:
  - count=1 after edge k;
  - state=START after edge k+1;
  - tx_start is high between edges k+1 and k+2.
- Back-to-back bytes: after WAIT_DONE->IDLE, the next START follows one cycle later, so the minimum gap is 1 IDLE cycle.
- tx_busy already high in IDLE (external sender use): the FSM waits in IDLE and never pulses tx_start.
- Arbitration and pushes continue in every FSM state.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter resets on entry to WAIT_BUSY and again on entry to WAIT_DONE.
  - If it reaches TIMEOUT in either state, the FSM goes to IDLE and tx_err pulses for 1 cycle.
  - The byte in flight is discarded, not re-queued.
- Not defined: no counter logic; tx_err is tied to 0; the WAIT states wait indefinitely.

Test Plan:
1. Reset, then req0 sends 0x55 with the sender model raising busy 2 cycles after start and holding it 10 cycles -> tx_start pulses once with tx_data=0x55, idle_irq pulses once after busy falls, fifo_count returns to 0.
2. Both requesters hold valid continuously (req0 0xA0.., req1 0xB0..) -> accept order is req0, req1, req0, req1; the sender sees 0xA0, 0xB0, 0xA1, 0xB1.
3. Sender held busy, 9 bytes offered with DEPTH=8 -> 8 accepted, fifo_count=8, req_ready all 0; release busy -> the 9th byte is accepted only after the first pop; all 9 bytes are transmitted in order.
4. Hold tx_busy=1 in IDLE with 1 byte queued -> no tx_start and count stays 1; drop busy -> tx_start occurs 1 cycle later.
5. Assert reset during WAIT_DONE with 3 bytes queued -> fifo_count=0 and tx_start=0 immediately; after release, no transmission occurs.
6. With UART_TX_ARB_TIMEOUT_EN and TIMEOUT=16, the sender never raises busy -> tx_err pulses 16 cycles after entering WAIT_BUSY, the FSM returns to IDLE, and the next queued byte starts. Without the macro, the FSM stays in WAIT_BUSY and tx_err stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin requester arbiter, byte FIFO and start/busy sequencer for a shared UART sender.
// Optional WAIT-state handshake timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   idle_irq,
    output logic                   tx_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [PW-1:0] ptr, gnt, c;
    logic          found, push, pop, expired;
    logic [AW-1:0] head, tail;
    logic [7:0]    mem [DEPTH];

    // Scan from farthest to nearest so the requester closest after ptr wins.
    always_comb begin
        found = 1'b0;
        gnt = ptr;
        c = ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            c = PW'((int'(ptr) + i) % NUM_REQ);
            if (req_valid[c]) begin
                found = 1'b1;
                gnt = c;
            end
        end
    end

    assign push      = found && fifo_count < FULL;
    assign req_ready = push ? NUM_REQ'(1) << gnt : '0;
    assign pop       = state == IDLE && fifo_count != '0 && !tx_busy;

    always_ff @(posedge sysclk)
        if (push) mem[tail] <= req_data[8*gnt +: 8];

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
            ptr        <= PW'(NUM_REQ - 1);
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
                ptr  <= gnt;
            end
            if (pop) head <= head + 1'b1;
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_start <= 1'b0;
            idle_irq <= 1'b0;
        end else begin
            tx_start <= pop;
            idle_irq <= state == WAIT_DONE && !tx_busy && fifo_count == '0;
            if (pop) tx_data <= mem[head];
            case (state)
                IDLE:      state <= pop ? START : IDLE;
                START:     state <= WAIT_BUSY;
                WAIT_BUSY: state <= tx_busy ? WAIT_DONE : expired ? IDLE : WAIT_BUSY;
                default:   state <= (!tx_busy || expired) ? IDLE : WAIT_DONE;
            endcase
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    assign expired = cnt == TW'(TIMEOUT - 1);

    // Counter restarts on entry to each WAIT state; free-running elsewhere is harmless.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            tx_err <= 1'b0;
        end else begin
            cnt    <= (state == START || (state == WAIT_BUSY && tx_busy)) ? '0 : cnt + 1'b1;
            tx_err <= expired && ((state == WAIT_BUSY && !tx_busy) || (state == WAIT_DONE && tx_busy));
        end
    end
`else
    assign expired = 1'b0 && (TIMEOUT > 0);
    assign tx_err  = 1'b0;
`endif
endmodule
